// File: rtl/fault_sim_sequencer.sv
// Exhaustive-pattern stuck-at fault simulation sequencer: captures the fault-free
// response, then one faulty pass per fault, reporting a per-pattern detection mask.
//
// state | meaning
// IDLE  | waiting for start, CUT driven fault-free with pi=0
// GOLD  | stepping all patterns fault-free, filling golden
// FAULT | stepping all patterns with fault k injected, mask reported at last pattern
module fault_sim_sequencer #(
  parameter int                    NUM_PI     = 3,
  parameter int                    NUM_FAULTS = 5,
  parameter logic [NUM_FAULTS-1:0] FF_CTRL    = 5'b10010,
  parameter int                    SETTLE     = 2
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  start,
  input  logic                                                  f_in,
  output logic [NUM_PI-1:0]                                     pi,
  output logic [NUM_FAULTS-1:0]                                 fault_ctrl,
  output logic [(1<<NUM_PI)-1:0]                                golden,
  output logic                                                  det_valid,
  output logic [((NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1)-1:0] det_fault_idx,
  output logic [(1<<NUM_PI)-1:0]                                det_mask,
  output logic [$clog2(NUM_FAULTS+1)-1:0]                       det_count,
  output logic                                                  busy,
  output logic                                                  done
);

  localparam int P  = 1 << NUM_PI;
  localparam int IW = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1;
  localparam int CW = $clog2(NUM_FAULTS + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, GOLD, FAULT} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   settle_cnt;
  logic [IW-1:0]   fault_k;
  logic [P-1:0]    faulty;
  logic [P-1:0]    faulty_w;
  logic [P-1:0]    golden_w;
  logic [P-1:0]    mask_nxt;
  logic            sample;
  logic            last_pat;
  logic            last_fault;

  assign sample     = (state != IDLE) && (settle_cnt == '0);
  assign last_pat   = sample && (pi == {NUM_PI{1'b1}});
  assign last_fault = (fault_k == IW'(NUM_FAULTS - 1));
  assign busy       = (state != IDLE);

  // Current pattern's sample merged in, so the last pattern's mask needs no extra cycle.
  always_comb begin
    faulty_w     = faulty;
    faulty_w[pi] = f_in;
    golden_w     = golden;
    golden_w[pi] = f_in;
    mask_nxt     = golden ^ faulty_w;
  end

  always_comb begin
    fault_ctrl = FF_CTRL;
    if (state == FAULT) fault_ctrl = FF_CTRL ^ (NUM_FAULTS'(1) << fault_k);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GOLD;
      GOLD:    if (last_pat) state_nxt = FAULT;
      FAULT:   if (last_pat && last_fault) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pi            <= '0;
      settle_cnt    <= '0;
      fault_k       <= '0;
      faulty        <= '0;
      golden        <= '0;
      det_valid     <= 1'b0;
      det_fault_idx <= '0;
      det_mask      <= '0;
      det_count     <= '0;
      done          <= 1'b0;
    end else begin
      det_valid <= 1'b0;
      done      <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          pi         <= '0;
          settle_cnt <= SW'(SETTLE - 1);
          fault_k    <= '0;
          faulty     <= '0;
          golden     <= '0;
          det_count  <= '0;
        end
      end else if (!sample) begin
        settle_cnt <= settle_cnt - SW'(1);
      end else begin
        settle_cnt <= SW'(SETTLE - 1);
        pi         <= pi + NUM_PI'(1);
        if (state == GOLD) begin
          golden <= golden_w;
          if (last_pat) fault_k <= '0;
        end else begin
          faulty <= faulty_w;
          if (last_pat) begin
            det_mask      <= mask_nxt;
            det_fault_idx <= fault_k;
            det_valid     <= 1'b1;
            det_count     <= det_count + CW'(mask_nxt != '0);
            if (last_fault) begin
              done    <= 1'b1;
              fault_k <= '0;
            end else begin
              fault_k <= fault_k + IW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fault_sim_sequencer.sv
// Directed bench for fault_sim_sequencer: behavioural fault-injectable CUT, table of
// run scenarios with hand-computed results, plus reset / start-handling sequences.
module tb_fault_sim_sequencer;

  logic clk = 1'b0;
  logic rst, start, sel, force0;
  logic start0, start1, f_in0, f_in1;

  logic [2:0] d0_pi, d1_pi;
  logic [4:0] d0_fc, d1_fc;
  logic [7:0] d0_golden, d1_golden, d0_mask, d1_mask;
  logic [2:0] d0_idx, d1_idx, d0_cnt, d1_cnt;
  logic       d0_valid, d1_valid, d0_busy, d1_busy, d0_done, d1_done;

  logic [2:0] mon_pi, mon_idx, mon_cnt;
  logic [4:0] mon_fc;
  logic [7:0] mon_golden, mon_mask;
  logic       mon_valid, mon_busy, mon_done;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Bench CUT: e=(a|a1)&(b&b0); f=((e|e1)|(c|c1))&f0, controls {f0,e1,c1,b0,a1}
  function automatic logic cut(input logic [2:0] p, input logic [4:0] fc);
    logic e;
    e = (p[2] | fc[0]) & (p[1] & fc[1]);
    return ((e | fc[3]) | (p[0] | fc[2])) & fc[4];
  endfunction

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign f_in0  = force0 ? 1'b0 : cut(d0_pi, d0_fc);
  assign f_in1  = force0 ? 1'b0 : cut(d1_pi, d1_fc);

  fault_sim_sequencer #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start0), .f_in(f_in0),
    .pi(d0_pi), .fault_ctrl(d0_fc), .golden(d0_golden), .det_valid(d0_valid),
    .det_fault_idx(d0_idx), .det_mask(d0_mask), .det_count(d0_cnt),
    .busy(d0_busy), .done(d0_done)
  );

  fault_sim_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f_in1),
    .pi(d1_pi), .fault_ctrl(d1_fc), .golden(d1_golden), .det_valid(d1_valid),
    .det_fault_idx(d1_idx), .det_mask(d1_mask), .det_count(d1_cnt),
    .busy(d1_busy), .done(d1_done)
  );

  assign mon_pi     = sel ? d1_pi     : d0_pi;
  assign mon_fc     = sel ? d1_fc     : d0_fc;
  assign mon_golden = sel ? d1_golden : d0_golden;
  assign mon_valid  = sel ? d1_valid  : d0_valid;
  assign mon_idx    = sel ? d1_idx    : d0_idx;
  assign mon_mask   = sel ? d1_mask   : d0_mask;
  assign mon_cnt    = sel ? d1_cnt    : d0_cnt;
  assign mon_busy   = sel ? d1_busy   : d0_busy;
  assign mon_done   = sel ? d1_done   : d0_done;

  typedef struct {
    bit             sel;
    bit             force0;
    bit             mid_pulse;
    bit             hold_end;
    bit             pre_reset;
    logic [7:0]     golden;
    logic [4:0][7:0] masks;
    logic [2:0]     count;
  } vec_t;

  vec_t vecs[5];
  logic [4:0] exp_fc[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " pi"}, 32'(mon_pi), 32'h0);
    chk({tag, " fault_ctrl"}, 32'(mon_fc), 32'h12);
    chk({tag, " golden"}, 32'(mon_golden), 32'h0);
    chk({tag, " det_valid"}, 32'(mon_valid), 32'h0);
    chk({tag, " det_fault_idx"}, 32'(mon_idx), 32'h0);
    chk({tag, " det_mask"}, 32'(mon_mask), 32'h0);
    chk({tag, " det_count"}, 32'(mon_cnt), 32'h0);
    chk({tag, " busy"}, 32'(mon_busy), 32'h0);
    chk({tag, " done"}, 32'(mon_done), 32'h0);
  endtask

  task automatic mid_run_reset();
    sel = 1'b0;
    force0 = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
  endtask

  task automatic do_run(input int vi, input vec_t v);
    int t, nv, ndone, done_t, per, lim;
    logic [7:0] gd, mk[5];
    logic [2:0] cd, pd, ix[5];
    logic [4:0] fcd, fc[6];
    logic       bz;
    int         vt[5];
    string      tg;
    tg = $sformatf("v%0d", vi);
    per = v.sel ? 8 : 16;
    lim = 6 * per + 4;
    sel = v.sel;
    force0 = v.force0;
    nv = 0; ndone = 0; done_t = -1;
    gd = 'x; cd = 'x; pd = 'x; fcd = 'x; bz = 1'bx;
    for (int k = 0; k < 5; k++) begin mk[k] = 'x; ix[k] = 'x; vt[k] = -1; end
    for (int j = 0; j < 6; j++) fc[j] = 'x;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    t = 0;
    chk({tg, " busy_after_start"}, 32'(mon_busy), 32'h1);
    while (t <= lim) begin
      if (v.mid_pulse && (t == 10 || t == 50)) start = 1'b1;
      else if (v.hold_end && t >= 6 * per - 1) start = 1'b1;
      else start = 1'b0;
      if (t % per == 1 && t / per < 6) fc[t / per] = mon_fc;
      if (mon_valid) begin
        if (nv < 5) begin mk[nv] = mon_mask; ix[nv] = mon_idx; vt[nv] = t; end
        nv++;
      end
      if (mon_done) begin
        ndone++; done_t = t;
        gd = mon_golden; cd = mon_cnt; pd = mon_pi; fcd = mon_fc; bz = mon_busy;
      end
      if (v.hold_end && t == 6 * per + 1) begin
        chk({tg, " restart_busy"}, 32'(mon_busy), 32'h1);
        chk({tg, " restart_golden_clr"}, 32'(mon_golden), 32'h0);
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    chk({tg, " golden"}, 32'(gd), 32'(v.golden));
    chk({tg, " det_count"}, 32'(cd), 32'(v.count));
    chk({tg, " n_valid"}, 32'(nv), 32'd5);
    chk({tg, " n_done"}, 32'(ndone), 32'd1);
    chk({tg, " done_time"}, 32'(done_t), 32'(6 * per));
    chk({tg, " busy_at_done"}, 32'(bz), 32'h0);
    chk({tg, " pi_at_done"}, 32'(pd), 32'h0);
    chk({tg, " fc_at_done"}, 32'(fcd), 32'h12);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s mask%0d", tg, k), 32'(mk[k]), 32'(v.masks[k]));
      chk($sformatf("%s idx%0d", tg, k), 32'(ix[k]), 32'(k));
      chk($sformatf("%s vtime%0d", tg, k), 32'(vt[k]), 32'((k + 2) * per));
    end
    for (int j = 0; j < 6; j++) chk($sformatf("%s fc%0d", tg, j), 32'(fc[j]), 32'(exp_fc[j]));
  endtask

  initial begin
    exp_fc = '{5'b10010, 5'b10011, 5'b10000, 5'b10110, 5'b11010, 5'b00010};
    //          sel f0 mid hold prerst golden  masks f4..f0                      count
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hEA, {8'hEA, 8'h15, 8'h15, 8'h40, 8'h04}, 3'd5};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hEA, {8'hEA, 8'h15, 8'h15, 8'h40, 8'h04}, 3'd5};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hEA, {8'hEA, 8'h15, 8'h15, 8'h40, 8'h04}, 3'd5};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hEA, {8'hEA, 8'h15, 8'h15, 8'h40, 8'h04}, 3'd5};

    rst = 1'b1; start = 1'b0; sel = 1'b0; force0 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    sel = 1'b1;
    check_reset("por1");
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].pre_reset) mid_run_reset();
      do_run(i, vecs[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
